mccpu_mem_responder: RTL

- Memory-side target for the multicycle CPU's unified instruction/data memory port.
- The CPU controller issues fetch, load and store accesses. This block accepts one access at a time over a valid/ready request handshake.
- It models configurable wait states, performs the word read or write, and returns a single-cycle response pulse with data and error status.
- It sits between the CPU datapath's address/write-data mux and the word storage array.

---
 rtl/mccpu_mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mccpu_mem_responder.sv
// Memory-side responder for the multicycle CPU's unified memory port: one access
// at a time, WAIT_CYCLES wait states, one-cycle response pulse. Optional macro: MEM_ALIGN_CHECK_EN.
module mccpu_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // the response is an unstalled one-cycle rsp_valid pulse with rsp_rdata/rsp_err.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              addr_err;
    logic [31:0]       mem [0:(2**ADDR_W)-1];

    assign addr_err  = (|req_addr[31:ADDR_W+2]) | (ALIGN_CHECK & (|req_addr[1:0]));
    assign req_ready = (state == IDLE) && !rst;
    assign dbg_state = state;

    // The commit edge is the one leaving RESP: array write, read capture and the
    // rsp_valid rise all happen there, so a reset any earlier aborts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        err_q   <= addr_err;
                        idx_q   <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (we_q || err_q) ? 32'h0 : mem[idx_q];
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && !err_q && !rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
